// File: rtl/ah_arb_pkg.sv
// Shared definitions for the 32-way round-robin arbiter and its requester agent.
package ah_arb_pkg;

    localparam int AH_ARB_N     = 32;
    localparam int AH_ARB_IDX_W = 5;

    // Non-zero with exactly one bit set: clearing the lowest set bit leaves nothing.
    function automatic logic ah_onehot(input logic [AH_ARB_N-1:0] v);
        return (v != '0) && ((v & (v - AH_ARB_N'(1))) == '0);
    endfunction

    function automatic logic [AH_ARB_IDX_W-1:0] ah_encode(input logic [AH_ARB_N-1:0] v);
        logic [AH_ARB_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < AH_ARB_N; i++) begin
            if (v[i]) idx = idx | AH_ARB_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ah_rr_client_slot.sv
// One client of the requester agent: pending token counter, request line and
// starvation tracking.
module ah_rr_client_slot #(
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 3,
    parameter int MAX_WAIT = 64,
    parameter int WAIT_W   = 7
) (
    input  logic clk,
    input  logic rstn,
    input  logic push,
    input  logic lg,
    output logic push_ready,
    output logic req,
    output logic starve
);

    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    logic [CNT_W-1:0]  count;
    logic [WAIT_W-1:0] wait_cnt;
    logic              accept;

    assign push_ready = (count < DEPTH_C);
    assign req        = (count != '0);
    assign accept     = push & push_ready;
    assign starve     = (wait_cnt == MAX_WAIT_C);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count    <= '0;
            wait_cnt <= '0;
        end else begin
            // A simultaneous accept and grant cancel out, keeping the slot at its level.
            if (accept && !lg) begin
                count <= count + CNT_W'(1);
            end else if (lg && !accept) begin
                count <= count - CNT_W'(1);
            end

            if (!req || lg) begin
                wait_cnt <= '0;
            end else if (!starve) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ah_rr_client_agent_32.sv
// Requester-side agent for the 32-way round-robin arbiter: turns posted tokens
// into req lines, consumes them on grants and reports winners and protocol errors.
module ah_rr_client_agent_32
    import ah_arb_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int CNT_W    = $clog2(DEPTH + 1),
    parameter int MAX_WAIT = 64,
    parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [AH_ARB_N-1:0]     push,
    output logic [AH_ARB_N-1:0]     push_ready,
    output logic [AH_ARB_N-1:0]     req,
    input  logic [AH_ARB_N-1:0]     grant,
    output logic [AH_ARB_N-1:0]     done,
    output logic                    gnt_valid,
    output logic [AH_ARB_IDX_W-1:0] gnt_id,
    output logic [AH_ARB_N-1:0]     starve,
    output logic                    err_spurious,
    output logic                    err_multi,
    input  logic                    err_clr
);

    // Token handshake: push[i] is taken on a rising clk edge only while
    // push_ready[i] is high; a push seen while push_ready[i] is low is dropped,
    // so clients must not rely on holding push to retry.

    logic                grant_onehot;
    logic [AH_ARB_N-1:0] lg;
    logic                spurious_hit;
    logic                multi_hit;

    assign grant_onehot = ah_onehot(grant);
    assign lg           = grant & req & {AH_ARB_N{grant_onehot}};
    assign spurious_hit = grant_onehot && ((grant & ~req) != '0);
    assign multi_hit    = (grant != '0) && !grant_onehot;

    for (genvar i = 0; i < AH_ARB_N; i++) begin : g_slot
        ah_rr_client_slot #(
            .DEPTH   (DEPTH),
            .CNT_W   (CNT_W),
            .MAX_WAIT(MAX_WAIT),
            .WAIT_W  (WAIT_W)
        ) u_slot (
            .clk       (clk),
            .rstn      (rstn),
            .push      (push[i]),
            .lg        (lg[i]),
            .push_ready(push_ready[i]),
            .req       (req[i]),
            .starve    (starve[i])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done         <= '0;
            gnt_valid    <= 1'b0;
            gnt_id       <= '0;
            err_spurious <= 1'b0;
            err_multi    <= 1'b0;
        end else begin
            done      <= lg;
            gnt_valid <= (lg != '0);
            gnt_id    <= (lg != '0) ? ah_encode(lg) : '0;

            // A fresh error outranks a clear landing in the same cycle.
            if (spurious_hit) begin
                err_spurious <= 1'b1;
            end else if (err_clr) begin
                err_spurious <= 1'b0;
            end

            if (multi_hit) begin
                err_multi <= 1'b1;
            end else if (err_clr) begin
                err_multi <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ah_rr_client_agent_32.sv
// Self-checking bench for ah_rr_client_agent_32: directed vector table, corner
// sequences and randomized traffic against a token-count reference model.
module tb_ah_rr_client_agent_32;

    localparam int N        = 32;
    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;
    localparam logic [31:0] FULL = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rstn;
    logic [N-1:0]  push;
    logic [N-1:0]  push_ready;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [N-1:0]  done;
    logic          gnt_valid;
    logic [4:0]    gnt_id;
    logic [N-1:0]  starve;
    logic          err_spurious;
    logic          err_multi;
    logic          err_clr;

    int checks = 0;
    int errors = 0;

    // scoreboard and reference model state
    logic [4:0]    exp_q[$];
    int            m_cnt[N];
    int            m_wait[N];
    logic [N-1:0]  m_done;
    logic          m_gv;
    logic [4:0]    m_gid;
    logic          m_es;
    logic          m_em;

    typedef struct {
        logic [31:0] push;
        logic [31:0] grant;
        logic [31:0] exp_req;
        logic [31:0] exp_ready;
        logic [31:0] exp_done;
        logic        exp_gv;
        logic [4:0]  exp_id;
    } vec_t;

    vec_t tbl[$];

    ah_rr_client_agent_32 #(
        .DEPTH   (DEPTH),
        .CNT_W   (3),
        .MAX_WAIT(MAX_WAIT),
        .WAIT_W  (4)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .push        (push),
        .push_ready  (push_ready),
        .req         (req),
        .grant       (grant),
        .done        (done),
        .gnt_valid   (gnt_valid),
        .gnt_id      (gnt_id),
        .starve      (starve),
        .err_spurious(err_spurious),
        .err_multi   (err_multi),
        .err_clr     (err_clr)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic logic [N-1:0] m_req();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (m_cnt[i] != 0);
        return v;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (m_cnt[i] < DEPTH);
        return v;
    endfunction

    function automatic logic [N-1:0] m_starve();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (m_wait[i] == MAX_WAIT);
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i]  = 0;
            m_wait[i] = 0;
        end
        m_done = '0;
        m_gv   = 1'b0;
        m_gid  = '0;
        m_es   = 1'b0;
        m_em   = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void check_model();
        chk("req", req, m_req());
        chk("push_ready", push_ready, m_ready());
        chk("starve", starve, m_starve());
        chk("done", done, m_done);
        chk("gnt_valid", 32'(gnt_valid), 32'(m_gv));
        chk("gnt_id", 32'(gnt_id), 32'(m_gid));
        chk("err_spurious", 32'(err_spurious), 32'(m_es));
        chk("err_multi", 32'(err_multi), 32'(m_em));
        if (gnt_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_grant actual=id%0d required=no_grant", gnt_id);
            end else begin
                chk("sb_gnt_id", 32'(gnt_id), 32'(exp_q.pop_front()));
            end
        end
    endfunction

    function automatic void model_step(logic [N-1:0] p, logic [N-1:0] g, logic c);
        logic [N-1:0] r;
        logic [N-1:0] nd;
        logic         oh;
        logic         acc;
        logic         l;
        r  = m_req();
        oh = ($countones(g) == 1);
        nd = '0;
        for (int i = 0; i < N; i++) begin
            acc = p[i] && (m_cnt[i] < DEPTH);
            l   = g[i] && (m_cnt[i] != 0) && oh;
            if (m_cnt[i] == 0 || l) m_wait[i] = 0;
            else if (m_wait[i] < MAX_WAIT) m_wait[i] = m_wait[i] + 1;
            m_cnt[i] = m_cnt[i] + int'(acc) - int'(l);
            nd[i] = l;
        end
        m_done = nd;
        m_gv   = (nd != '0);
        m_gid  = '0;
        for (int i = 0; i < N; i++) if (nd[i]) m_gid = 5'(i);
        if (m_gv) exp_q.push_back(m_gid);
        if (oh && ((g & ~r) != '0)) m_es = 1'b1;
        else if (c) m_es = 1'b0;
        if (g != '0 && !oh) m_em = 1'b1;
        else if (c) m_em = 1'b0;
    endfunction

    // driver tasks: inputs change at posedge+1, checks at negedge
    task automatic finish_cycle(input logic [N-1:0] p, input logic [N-1:0] g, input logic c);
        check_model();
        model_step(p, g, c);
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic [N-1:0] p, input logic [N-1:0] g, input logic c);
        push    = p;
        grant   = g;
        err_clr = c;
        @(negedge clk);
        finish_cycle(p, g, c);
    endtask

    task automatic add(input logic [31:0] p, input logic [31:0] g, input logic [31:0] er,
                       input logic [31:0] epr, input logic [31:0] ed, input logic egv,
                       input logic [4:0] eid);
        vec_t v;
        v.push = p; v.grant = g; v.exp_req = er; v.exp_ready = epr;
        v.exp_done = ed; v.exp_gv = egv; v.exp_id = eid;
        tbl.push_back(v);
    endtask

    task automatic random_cycle();
        logic [N-1:0] p;
        logic [N-1:0] g;
        logic         c;
        logic         found;
        int           r;
        int           k;
        int           idx;
        p = $urandom & $urandom & $urandom;
        g = '0;
        r = $urandom_range(0, 99);
        if (r < 70) begin
            k = $urandom_range(0, N - 1);
            found = 1'b0;
            for (int j = 0; j < N; j++) begin
                idx = (k + j) % N;
                if (!found && m_cnt[idx] != 0) begin
                    g[idx] = 1'b1;
                    found  = 1'b1;
                end
            end
        end else if (r < 80) begin
            g[$urandom_range(0, N - 1)] = 1'b1;
        end else if (r < 86) begin
            g[$urandom_range(0, 15)]  = 1'b1;
            g[$urandom_range(16, 31)] = 1'b1;
        end
        c = ($urandom_range(0, 24) == 0);
        cycle(p, g, c);
    endtask

    initial begin
        rstn    = 1'b0;
        push    = '0;
        grant   = '0;
        err_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // reset state and idle
        chk("rst_req", req, 32'h0);
        chk("rst_push_ready", push_ready, FULL);
        chk("rst_done", done, 32'h0);
        chk("rst_gnt_valid", 32'(gnt_valid), 32'h0);
        chk("rst_gnt_id", 32'(gnt_id), 32'h0);
        chk("rst_starve", starve, 32'h0);
        chk("rst_err_spurious", 32'(err_spurious), 32'h0);
        chk("rst_err_multi", 32'(err_multi), 32'h0);
        repeat (2) cycle('0, '0, 1'b0);

        // client 3: three tokens, three separate grants
        add(32'h8, 0,     0,     FULL, 0,     0, 0);
        add(32'h8, 0,     32'h8, FULL, 0,     0, 0);
        add(32'h8, 0,     32'h8, FULL, 0,     0, 0);
        add(0,     32'h8, 32'h8, FULL, 0,     0, 0);
        add(0,     0,     32'h8, FULL, 32'h8, 1, 3);
        add(0,     32'h8, 32'h8, FULL, 0,     0, 0);
        add(0,     32'h8, 32'h8, FULL, 32'h8, 1, 3);
        add(0,     0,     0,     FULL, 32'h8, 1, 3);
        add(0,     0,     0,     FULL, 0,     0, 0);
        // client 0: five pushes into a depth-4 slot, four grants to drain
        add(32'h1, 0,     0,     FULL,         0,     0, 0);
        add(32'h1, 0,     32'h1, FULL,         0,     0, 0);
        add(32'h1, 0,     32'h1, FULL,         0,     0, 0);
        add(32'h1, 0,     32'h1, FULL,         0,     0, 0);
        add(32'h1, 0,     32'h1, 32'hFFFFFFFE, 0,     0, 0);
        add(0,     32'h1, 32'h1, 32'hFFFFFFFE, 0,     0, 0);
        add(0,     32'h1, 32'h1, FULL,         32'h1, 1, 0);
        add(0,     32'h1, 32'h1, FULL,         32'h1, 1, 0);
        add(0,     32'h1, 32'h1, FULL,         32'h1, 1, 0);
        add(0,     0,     0,     FULL,         32'h1, 1, 0);
        add(0,     0,     0,     FULL,         0,     0, 0);
        // client 9: push and grant in the same cycle at count 1
        add(32'h200, 0,       0,       FULL, 0,       0, 0);
        add(32'h200, 32'h200, 32'h200, FULL, 0,       0, 0);
        add(0,       0,       32'h200, FULL, 32'h200, 1, 9);
        add(0,       32'h200, 32'h200, FULL, 0,       0, 0);
        add(0,       0,       0,       FULL, 32'h200, 1, 9);
        add(0,       0,       0,       FULL, 0,       0, 0);

        foreach (tbl[k]) begin
            push    = tbl[k].push;
            grant   = tbl[k].grant;
            err_clr = 1'b0;
            @(negedge clk);
            chk($sformatf("tbl%0d_req", k), req, tbl[k].exp_req);
            chk($sformatf("tbl%0d_ready", k), push_ready, tbl[k].exp_ready);
            chk($sformatf("tbl%0d_done", k), done, tbl[k].exp_done);
            chk($sformatf("tbl%0d_gv", k), 32'(gnt_valid), 32'(tbl[k].exp_gv));
            chk($sformatf("tbl%0d_id", k), 32'(gnt_id), 32'(tbl[k].exp_id));
            finish_cycle(tbl[k].push, tbl[k].grant, 1'b0);
        end

        // spurious grant, multi grant, clear racing a new error, clear
        cycle('0, 32'h80, 1'b0);
        chk("spur_flag", 32'(err_spurious), 32'h1);
        chk("spur_gv", 32'(gnt_valid), 32'h0);
        cycle(32'h3, '0, 1'b0);
        cycle('0, 32'h3, 1'b0);
        chk("multi_flag", 32'(err_multi), 32'h1);
        chk("multi_req_kept", req, 32'h3);
        chk("multi_gv", 32'(gnt_valid), 32'h0);
        cycle('0, 32'h3, 1'b1);
        chk("clr_race_multi", 32'(err_multi), 32'h1);
        chk("clr_race_spur", 32'(err_spurious), 32'h0);
        cycle('0, '0, 1'b1);
        chk("clr_multi", 32'(err_multi), 32'h0);
        chk("clr_spur", 32'(err_spurious), 32'h0);
        cycle('0, 32'h1, 1'b0);
        cycle('0, 32'h2, 1'b0);
        chk("drain_done", done, 32'h2);
        chk("drain_id", 32'(gnt_id), 32'h1);
        cycle('0, '0, 1'b0);

        // starvation of client 5
        cycle(32'h20, '0, 1'b0);
        repeat (7) cycle('0, '0, 1'b0);
        chk("starve_before", starve, 32'h0);
        cycle('0, '0, 1'b0);
        chk("starve_set", starve, 32'h20);
        cycle('0, 32'h20, 1'b0);
        chk("starve_clear", starve, 32'h0);
        chk("starve_done", done, 32'h20);
        chk("starve_req", req, 32'h0);

        // asynchronous reset with clients 2 and 4 pending
        cycle(32'h14, '0, 1'b0);
        cycle(32'h14, '0, 1'b0);
        cycle('0, 32'h4, 1'b0);
        push  = 32'h4;
        grant = 32'h10;
        #3 rstn = 1'b0;
        #1;
        chk("arst_req", req, 32'h0);
        chk("arst_ready", push_ready, FULL);
        chk("arst_done", done, 32'h0);
        chk("arst_gv", 32'(gnt_valid), 32'h0);
        model_reset();
        push  = '0;
        grant = '0;
        @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_after_req", req, 32'h0);
        repeat (2) cycle('0, '0, 1'b0);

        // randomized traffic
        repeat (700) random_cycle();
        repeat (2) cycle('0, '0, 1'b0);
        chk("exp_q_empty", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
